// File: rtl/ppwm_core.sv
// Multi-channel PWM generator sharing one prescaled timebase.
// Duty/period writes are double-buffered and take effect at period boundaries.
module ppwm_core #(
  parameter int NUM_CH  = 4,
  parameter int WIDTH   = 8,
  parameter int PRESC_W = 8,
  localparam int AW     = $clog2(NUM_CH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               wr_en,
  input  logic [AW-1:0]      wr_addr,
  input  logic [WIDTH-1:0]   wr_data,
  input  logic               cfg_center,
  input  logic [PRESC_W-1:0] cfg_presc,
  input  logic [NUM_CH-1:0]  pol,
  output logic [NUM_CH-1:0]  pwm_out,
  output logic               period_start,
  output logic [WIDTH-1:0]   cnt_out
);

  localparam logic [AW-1:0] PER_ADDR = AW'(NUM_CH);

  logic [PRESC_W-1:0] presc_reg, presc_act_reg;
  logic [WIDTH-1:0]   cnt_reg, cnt_next;
  logic [WIDTH-1:0]   per_pend_reg, per_act_reg;
  logic               dir_reg, dir_next;
  logic               mode_act_reg;
  logic               ps_reg;
  logic               tick, wrap_next, boundary, load_act, wr_per, at_top;

  // >= rather than == keeps the timebase sane if the active values shrank while held
  assign tick     = en && (presc_reg >= presc_act_reg);
  assign at_top   = (cnt_reg >= per_act_reg);
  assign boundary = tick && wrap_next;
  assign load_act = !en || boundary;
  assign wr_per   = wr_en && (wr_addr == PER_ADDR);

  always_comb begin
    cnt_next  = cnt_reg + 1'b1;
    dir_next  = dir_reg;
    wrap_next = 1'b0;
    if (!mode_act_reg) begin
      if (at_top) begin
        cnt_next  = '0;
        wrap_next = 1'b1;
      end
    end else if (per_act_reg == '0) begin
      cnt_next  = '0;
      wrap_next = 1'b1;
    end else if (dir_reg) begin
      if (at_top && per_act_reg == WIDTH'(1)) begin
        cnt_next  = '0;
        wrap_next = 1'b1;
      end else if (at_top) begin
        cnt_next = per_act_reg - 1'b1;
        dir_next = 1'b0;
      end
    end else if (cnt_reg <= WIDTH'(1)) begin
      cnt_next  = '0;
      wrap_next = 1'b1;
    end else begin
      cnt_next = cnt_reg - 1'b1;
    end
    if (wrap_next) dir_next = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_reg     <= '0;
      cnt_reg       <= '0;
      dir_reg       <= 1'b1;
      per_pend_reg  <= '1;
      per_act_reg   <= '1;
      mode_act_reg  <= 1'b0;
      presc_act_reg <= '0;
      ps_reg        <= 1'b0;
    end else begin
      if (wr_per) per_pend_reg <= wr_data;
      if (load_act) begin
        per_act_reg   <= wr_per ? wr_data : per_pend_reg;
        mode_act_reg  <= cfg_center;
        presc_act_reg <= cfg_presc;
      end
      if (en) begin
        presc_reg <= tick ? '0 : presc_reg + 1'b1;
        if (tick) begin
          cnt_reg <= cnt_next;
          dir_reg <= dir_next;
        end
      end
      ps_reg <= boundary;
    end
  end

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    logic [WIDTH-1:0] duty_pend_reg, duty_act_reg;
    logic             pwm_reg, wr_hit;

    assign wr_hit      = wr_en && (wr_addr == AW'(gi));
    assign pwm_out[gi] = pwm_reg;

    always_ff @(posedge clk) begin
      if (rst) begin
        duty_pend_reg <= '0;
        duty_act_reg  <= '0;
        pwm_reg       <= 1'b0;
      end else begin
        if (wr_hit) duty_pend_reg <= wr_data;
        if (load_act) duty_act_reg <= wr_hit ? wr_data : duty_pend_reg;
        pwm_reg <= en ? ((cnt_reg < duty_act_reg) ^ pol[gi]) : pol[gi];
      end
    end
  end

  assign period_start = ps_reg;
  assign cnt_out      = cnt_reg;

endmodule

// File: tb/tb_ppwm_core.sv
// Scoreboard bench for ppwm_core: stimulus queues expected outputs per cycle,
// a negedge monitor pops and compares them.
module tb_ppwm_core;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       wr_en = 1'b0;
  logic [2:0] wr_addr = '0;
  logic [7:0] wr_data = '0;
  logic       cfg_center = 1'b0;
  logic [7:0] cfg_presc = '0;
  logic [3:0] pol = '0;
  logic [3:0] pwm_out;
  logic       period_start;
  logic [7:0] cnt_out;

  int cyc = 0;
  int checks = 0;
  int passed = 0;

  typedef struct {
    int    cyc;
    int    sel;
    int    val;
    string tag;
  } exp_t;
  exp_t sb[$];

  ppwm_core #(.NUM_CH(4), .WIDTH(8), .PRESC_W(8)) dut (
    .clk(clk), .rst(rst), .en(en), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .cfg_center(cfg_center), .cfg_presc(cfg_presc),
    .pol(pol), .pwm_out(pwm_out), .period_start(period_start), .cnt_out(cnt_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compare every queued expectation due in this cycle
  initial begin
    int    i, act;
    string sig;
    forever begin
      @(negedge clk);
      i = 0;
      while (i < sb.size()) begin
        if (sb[i].cyc <= cyc) begin
          case (sb[i].sel)
            0:       begin act = int'(pwm_out);      sig = "pwm_out";      end
            1:       begin act = int'(period_start); sig = "period_start"; end
            default: begin act = int'(cnt_out);      sig = "cnt_out";      end
          endcase
          checks++;
          if (sb[i].cyc == cyc && act == sb[i].val) passed++;
          else $display("FAIL %s %s cyc=%0d got=%0d want=%0d (due cyc %0d)",
                        sb[i].tag, sig, cyc, act, sb[i].val, sb[i].cyc);
          sb.delete(i);
        end else begin
          i++;
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL timeout cyc=%0d got=running want=finished", cyc);
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) step();
  endtask

  task automatic push(input int c, input int sel, input int val, input string tag);
    exp_t e;
    e.cyc = c; e.sel = sel; e.val = val; e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic push3(input int c, input int pw, input int ps, input int cn, input string tag);
    push(c, 0, pw, tag);
    push(c, 1, ps, tag);
    push(c, 2, cn, tag);
  endtask

  // Counter value after t ticks from a fresh period start
  function automatic int mcnt(input bit center, input int n, input int t);
    int p;
    if (!center) return t % (n + 1);
    if (n == 0) return 0;
    p = t % (2 * n);
    return (p <= n) ? p : 2 * n - p;
  endfunction

  // Expected outputs for edges s+1+j, j0..j1, of a run starting at cnt 0, dir up
  task automatic expect_run(input int s, input int j0, input int j1, input bit center,
                            input int p, input int n, input int d0, input int d1,
                            input int d2, input int d3, input logic [3:0] pl,
                            input string tag);
    int d[4];
    int per, tb, ta, c;
    logic [3:0] w;
    d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
    per = center ? ((n == 0) ? 1 : 2 * n) : n + 1;
    for (int j = j0; j <= j1; j++) begin
      tb = j / (p + 1);
      ta = (j + 1) / (p + 1);
      c  = mcnt(center, n, tb);
      for (int i = 0; i < 4; i++) w[i] = (c < d[i]) ^ pl[i];
      push3(s + 1 + j, int'(w), ((j % (p + 1)) == p && (ta % per) == 0) ? 1 : 0,
            mcnt(center, n, ta), tag);
    end
  endtask

  task automatic wr(input int a, input int d);
    wr_en = 1'b1; wr_addr = 3'(a); wr_data = 8'(d);
    $display("cyc=%0d write addr=%0d data=%0d", cyc, a, d);
    step();
    wr_en = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; wr_en = 1'b0;
    step();
    push3(cyc, 0, 0, 0, "reset");
    rst = 1'b0;
  endtask

  task automatic setup(input bit center, input int p, input int n, input int d0,
                       input int d1, input int d2, input int d3, input logic [3:0] pl);
    do_reset();
    cfg_center = center; cfg_presc = 8'(p); pol = pl;
    wr(4, n); wr(0, d0); wr(1, d1); wr(2, d2); wr(3, d3);
    step();
    push3(cyc, int'(pl), 0, 0, "idle_pol");
  endtask

  initial begin
    int base;
    step(); step();
    checks++;
    if (cnt_out == 8'd0 && pwm_out == 4'd0 && period_start == 1'b0) passed++;
    else $display("FAIL init_reset cyc=%0d got=cnt%0d/pwm%0d/ps%0d want=0/0/0",
                  cyc, cnt_out, pwm_out, period_start);

    // Edge mode P=0 per=9, duty 3/5/0/200, ch1 inverted, stray writes to 7 and 5
    setup(0, 0, 9, 3, 5, 0, 200, 4'b0010);
    base = cyc;
    expect_run(base, 0, 29, 0, 0, 9, 3, 5, 0, 200, 4'b0010, "edge_p0");
    en = 1'b1;
    wait_until(base + 6);
    wr(7, 1);
    wr(5, 1);
    wait_until(base + 31);

    // Prescale 1, then switch to 0 mid-period: effective after next boundary
    setup(0, 1, 9, 3, 9, 10, 1, 4'b0000);
    base = cyc;
    expect_run(base, 0, 39, 0, 1, 9, 3, 9, 10, 1, 4'b0000, "presc1");
    expect_run(base + 40, 0, 24, 0, 0, 9, 3, 9, 10, 1, 4'b0000, "presc0");
    en = 1'b1;
    wait_until(base + 26);
    cfg_presc = 8'd0;
    wait_until(base + 66);

    // Shadowing: mid-period write, then a write in the boundary cycle
    setup(0, 0, 9, 3, 1, 2, 4, 4'b0000);
    base = cyc;
    expect_run(base, 0, 9, 0, 0, 9, 3, 1, 2, 4, 4'b0000, "shadow_old");
    expect_run(base + 10, 0, 9, 0, 0, 9, 7, 1, 2, 4, 4'b0000, "shadow_new");
    expect_run(base + 20, 0, 19, 0, 0, 9, 2, 1, 2, 4, 4'b0000, "shadow_bypass");
    en = 1'b1;
    wait_until(base + 5);
    wr(0, 7);
    wait_until(base + 19);
    wr(0, 2);
    wait_until(base + 41);

    // Center mode per=4
    setup(1, 0, 4, 2, 0, 4, 5, 4'b1000);
    base = cyc;
    expect_run(base, 0, 23, 1, 0, 4, 2, 0, 4, 5, 4'b1000, "center");
    en = 1'b1;
    wait_until(base + 25);

    // per=0 edge mode: cnt stuck at 0, period_start every tick
    setup(0, 0, 0, 1, 0, 0, 0, 4'b0000);
    base = cyc;
    expect_run(base, 0, 7, 0, 0, 0, 1, 0, 0, 0, 4'b0000, "per0");
    en = 1'b1;
    wait_until(base + 9);

    // Duty above period is 100 %, duty == period misses only the top count
    setup(0, 0, 100, 200, 100, 101, 0, 4'b0000);
    base = cyc;
    expect_run(base, 0, 109, 0, 0, 100, 200, 100, 101, 0, 4'b0000, "duty_gt_per");
    en = 1'b1;
    wait_until(base + 111);

    // Enable drop at cnt 6: hold, outputs to pol, resume at 7
    setup(0, 0, 9, 3, 5, 0, 200, 4'b0101);
    base = cyc;
    expect_run(base, 0, 5, 0, 0, 9, 3, 5, 0, 200, 4'b0101, "en_run");
    for (int k = 7; k <= 9; k++) push3(base + k, 5, 0, 6, "en_hold");
    expect_run(base + 3, 6, 25, 0, 0, 9, 3, 5, 0, 200, 4'b0101, "en_resume");
    en = 1'b1;
    wait_until(base + 6);
    en = 1'b0;
    wait_until(base + 9);
    en = 1'b1;
    wait_until(base + 30);

    // Reset at cnt 6 together with a duty write: write is discarded
    setup(0, 0, 9, 3, 3, 3, 3, 4'b0000);
    base = cyc;
    expect_run(base, 0, 5, 0, 0, 9, 3, 3, 3, 3, 4'b0000, "rst_run");
    push3(base + 7, 0, 0, 0, "rst_mid");
    push3(base + 8, 0, 0, 0, "rst_idle");
    push3(base + 9, 0, 0, 0, "rst_idle");
    expect_run(base + 9, 0, 29, 0, 0, 255, 0, 0, 0, 0, 4'b0000, "rst_after");
    en = 1'b1;
    wait_until(base + 6);
    rst = 1'b1; wr_en = 1'b1; wr_addr = 3'd0; wr_data = 8'd5;
    $display("cyc=%0d write addr=0 data=5 with reset", cyc);
    step();
    rst = 1'b0; wr_en = 1'b0; en = 1'b0;
    wait_until(base + 9);
    en = 1'b1;
    wait_until(base + 40);

    step(); step();
    while (sb.size() > 0) begin
      checks++;
      $display("FAIL unchecked %s due=%0d got=none want=%0d", sb[0].tag, sb[0].cyc, sb[0].val);
      void'(sb.pop_front());
    end
    $display("%0d/%0d checks passed", passed, checks);
    if (passed == checks && checks >= 12) $display("PASS all %0d checks", checks);
    else $display("FAIL summary got=%0d want=%0d", passed, checks);
    $finish;
  end

endmodule
